// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU constants and types used by the operand-fetch stage and its
// scoreboard.
//   DATA_W      : operand / writeback data width
//   NUM_REGS    : architectural register count
//   REG_ADDR_W  : register address width
//   REG_ZERO    : hard-wired zero register address
// Ports: none (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    function automatic logic is_reg_zero(input reg_addr_t addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
// Bundles every non-clock/reset signal of the operand-fetch stage.
//   decode side   : in_valid, in_ready, in_rs, in_rt, in_rd, in_wr_en
//   register file : rf_raddr1, rf_raddr2, rf_rdata1, rf_rdata2
//   writeback     : wb_en, wb_addr, wb_data
//   control       : flush
//   execute side  : out_valid, out_ready, out_a, out_b, out_rd, out_wr_en
// Modports:
//   master : surrounding pipeline (drives decode, RF data, writeback, flush,
//            out_ready)
//   slave  : operand_fetch stage
// -----------------------------------------------------------------------------
interface operand_fetch_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W
);

    logic              in_valid;
    logic              in_ready;
    reg_addr_t         in_rs;
    reg_addr_t         in_rt;
    reg_addr_t         in_rd;
    logic              in_wr_en;

    reg_addr_t         rf_raddr1;
    reg_addr_t         rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    logic              wb_en;
    reg_addr_t         wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    reg_addr_t         out_rd;
    logic              out_wr_en;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_wr_en,
        input  in_ready,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        output wb_en, wb_addr, wb_data,
        output flush,
        input  out_valid, out_a, out_b, out_rd, out_wr_en,
        output out_ready
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_wr_en,
        output in_ready,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        input  wb_en, wb_addr, wb_data,
        input  flush,
        output out_valid, out_a, out_b, out_rd, out_wr_en,
        input  out_ready
    );

endinterface

// File: rtl/operand_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_scoreboard
// Pending-write bit vector: one bit per architectural register, set when an
// instruction that writes the register enters the output stage, cleared on
// writeback or when that instruction is flushed. Register zero never pends.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   set_en/addr   : mark a register pending (wins over any clear)
//   clr_en/addr   : writeback clear
//   flush_en/addr : clear for a flushed output-stage instruction
//   pending       : current scoreboard
// -----------------------------------------------------------------------------
module operand_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                set_en,
    input  reg_addr_t           set_addr,
    input  logic                clr_en,
    input  reg_addr_t           clr_addr,
    input  logic                flush_en,
    input  reg_addr_t           flush_addr,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_nxt;

    // Clears are applied first so that a set to the same register in the same
    // cycle survives.
    always_comb begin
        pending_nxt = pending;
        if (clr_en && !is_reg_zero(clr_addr))
            pending_nxt[clr_addr] = 1'b0;
        if (flush_en && !is_reg_zero(flush_addr))
            pending_nxt[flush_addr] = 1'b0;
        if (set_en && !is_reg_zero(set_addr))
            pending_nxt[set_addr] = 1'b1;
        pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Register-read stage: reads both source operands from the register file,
// stalls on read-after-write / write-after-write hazards tracked by a pending
// scoreboard, and holds one instruction in a single output register slice
// towards the execute stage.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset (clears scoreboard and output stage)
//   bus : operand_fetch_if.slave (decode, register file, writeback, flush,
//         execute handshake)
// Build option:
//   FORWARD_EN : when defined, a source whose writeback is on the bus in the
//                same cycle is taken from wb_data instead of stalling.
// -----------------------------------------------------------------------------
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic            CLK,
    input  logic            RST,
    operand_fetch_if.slave  bus
);

    logic [NUM_REGS-1:0] pending;
    logic                fwd_a;
    logic                fwd_b;
    logic                hazard;
    logic                in_ready;
    logic                accept;
    logic                flush_clr;
    logic [DATA_W-1:0]   opnd_a;
    logic [DATA_W-1:0]   opnd_b;

    logic                out_valid;
    logic [DATA_W-1:0]   out_a;
    logic [DATA_W-1:0]   out_b;
    reg_addr_t           out_rd;
    logic                out_wr_en;

    assign bus.rf_raddr1 = bus.in_rs;
    assign bus.rf_raddr2 = bus.in_rt;

    always_comb begin
        fwd_a = 1'b0;
        fwd_b = 1'b0;
`ifdef FORWARD_EN
        // A writeback landing this cycle satisfies the pending source directly.
        fwd_a = bus.wb_en && (bus.wb_addr == bus.in_rs) && !is_reg_zero(bus.in_rs);
        fwd_b = bus.wb_en && (bus.wb_addr == bus.in_rt) && !is_reg_zero(bus.in_rt);
`endif
        hazard = (pending[bus.in_rs] && !fwd_a) ||
                 (pending[bus.in_rt] && !fwd_b) ||
                 (bus.in_wr_en && pending[bus.in_rd]);

        // RST gating keeps the handshake closed while reset is held.
        in_ready = !RST && !hazard && !bus.flush && (!out_valid || bus.out_ready);
        accept   = bus.in_valid && in_ready;

        if (is_reg_zero(bus.in_rs))
            opnd_a = '0;
        else if (fwd_a)
            opnd_a = bus.wb_data;
        else
            opnd_a = bus.rf_rdata1;

        if (is_reg_zero(bus.in_rt))
            opnd_b = '0;
        else if (fwd_b)
            opnd_b = bus.wb_data;
        else
            opnd_b = bus.rf_rdata2;

        // A flushed writer will never write back, so its pending bit is dropped.
        flush_clr = bus.flush && out_valid && out_wr_en;
    end

    operand_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .set_en     (accept && bus.in_wr_en),
        .set_addr   (bus.in_rd),
        .clr_en     (bus.wb_en),
        .clr_addr   (bus.wb_addr),
        .flush_en   (flush_clr),
        .flush_addr (out_rd),
        .pending    (pending)
    );

    // ---- output stage register ----
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_wr_en <= 1'b0;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= opnd_a;
            out_b     <= opnd_b;
            out_rd    <= bus.in_rd;
            out_wr_en <= bus.in_wr_en;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_a     = out_a;
    assign bus.out_b     = out_b;
    assign bus.out_rd    = out_rd;
    assign bus.out_wr_en = out_wr_en;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch: reset, RAW stall / bypass, register zero,
// backpressure, flush, set/clear collision and reset during a stall.
// The register file is modelled here; it is written one step after each
// writeback edge so the DUT always sees the pre-write value on that edge.
// -----------------------------------------------------------------------------
module tb_operand_fetch;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];

    operand_fetch_if #(.DATA_W(32)) bus ();

    operand_fetch #(
        .DATA_W   (32),
        .NUM_REGS (32)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input reg_addr_t rs, input reg_addr_t rt,
                           input reg_addr_t rd, input logic wr);
        bus.in_valid = v;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_wr_en = wr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.wb_en && bus.wb_addr != 5'd0)
            regs[bus.wb_addr] = bus.wb_data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = 32'h100 + i;
        regs[0] = 32'hDEAD;   // must never reach an operand

        RST           = 1'b1;
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.wb_en     = 1'b0;
        bus.wb_addr   = 5'd0;
        bus.wb_data   = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #3;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_pending", dut.pending, 32'h0);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1 check("post_rst_in_ready", bus.in_ready, 1'b1);

        // First accept: rs=1, rt=2, writes r5
        present(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        #1 check("acc1_in_ready", bus.in_ready, 1'b1);
        tick();
        check("acc1_out_valid", bus.out_valid, 1'b1);
        check("acc1_out_a", bus.out_a, 32'h101);
        check("acc1_out_b", bus.out_b, 32'h102);
        check("acc1_out_rd", bus.out_rd, 5'd5);
        check("acc1_out_wr_en", bus.out_wr_en, 1'b1);
        check("acc1_pending", dut.pending, 32'h20);

        // RAW on r5
        present(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
        #1 check("raw_stall", bus.in_ready, 1'b0);
        tick();
        check("raw_drain_out_valid", bus.out_valid, 1'b0);

        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd5;
        bus.wb_data = 32'h1234;
`ifdef FORWARD_EN
        #1 check("raw_fwd_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.wb_en = 1'b0;
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`else
        #1 check("raw_wb_still_stall", bus.in_ready, 1'b0);
        tick();
        bus.wb_en = 1'b0;
        #1 check("raw_after_wb_in_ready", bus.in_ready, 1'b1);
        tick();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`endif
        check("raw_out_valid", bus.out_valid, 1'b1);
        check("raw_out_a", bus.out_a, 32'h1234);
        check("raw_out_rd", bus.out_rd, 5'd6);
        check("raw_pending", dut.pending, 32'h40);

        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd6;
        bus.wb_data = 32'h66;
        tick();
        bus.wb_en = 1'b0;
        check("wb6_pending", dut.pending, 32'h0);

        // Register zero: writing r0 never pends, reading r0 yields 0
        present(1'b1, 5'd0, 5'd3, 5'd0, 1'b1);
        #1 check("r0_wr_in_ready", bus.in_ready, 1'b1);
        tick();
        check("r0_wr_pending", dut.pending, 32'h0);
        check("r0_wr_out_a", bus.out_a, 32'h0);
        check("r0_wr_out_b", bus.out_b, 32'h103);
        present(1'b1, 5'd0, 5'd0, 5'd4, 1'b0);
        #1 check("r0_rd_no_stall", bus.in_ready, 1'b1);
        tick();
        check("r0_rd_out_a", bus.out_a, 32'h0);
        check("r0_rd_out_b", bus.out_b, 32'h0);

        // Backpressure
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check("bp_drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        present(1'b1, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        check("bp_load_out_a", bus.out_a, 32'h101);
        present(1'b1, 5'd3, 5'd4, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", bus.in_ready, 1'b0);
            tick();
            check("bp_hold_valid", bus.out_valid, 1'b1);
            check("bp_hold_out_a", bus.out_a, 32'h101);
            check("bp_hold_out_b", bus.out_b, 32'h102);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_in_ready", bus.in_ready, 1'b1);
        tick();
        check("bp_xfer1_out_a", bus.out_a, 32'h103);
        check("bp_xfer1_out_b", bus.out_b, 32'h104);
        present(1'b1, 5'd7, 5'd8, 5'd0, 1'b0);
        tick();
        check("bp_xfer2_valid", bus.out_valid, 1'b1);
        check("bp_xfer2_out_a", bus.out_a, 32'h107);
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Flush of a writer to r7
        present(1'b1, 5'd1, 5'd1, 5'd7, 1'b1);
        tick();
        check("fl_pending_set", dut.pending, 32'h80);
        check("fl_out_rd", bus.out_rd, 5'd7);
        present(1'b1, 5'd7, 5'd0, 5'd8, 1'b0);
        bus.flush = 1'b1;
        #1 check("fl_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.flush = 1'b0;
        check("fl_out_valid", bus.out_valid, 1'b0);
        check("fl_pending_clr", dut.pending, 32'h0);
        #1 check("fl_rs7_no_stall", bus.in_ready, 1'b1);
        tick();
        check("fl_rs7_out_valid", bus.out_valid, 1'b1);
        check("fl_rs7_out_a", bus.out_a, 32'h107);

        // Set and writeback clear on r9 in the same cycle
        present(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        bus.wb_data = 32'h999;
        #1 check("coll_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.wb_en = 1'b0;
        check("coll_pending", dut.pending, 32'h200);

        // Reset while stalled on r3
        present(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        check("ms_pending", dut.pending, 32'h208);
        bus.out_ready = 1'b0;
        present(1'b1, 5'd3, 5'd0, 5'd10, 1'b1);
        #1 check("ms_stall", bus.in_ready, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("ms_rst_out_valid", bus.out_valid, 1'b0);
        check("ms_rst_pending", dut.pending, 32'h0);
        check("ms_rst_out_rd", bus.out_rd, 5'd0);
        check("ms_rst_out_wr_en", bus.out_wr_en, 1'b0);
        check("ms_rst_in_ready", bus.in_ready, 1'b0);
        RST = 1'b0;
        #1 check("ms_post_rst_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
